spi_apb_arbiter: RTL
====================

Name: spi_apb_arbiter

Overview:
- Two-requester APB arbiter placed in front of the SPI/XIP APB completer (the spi_top_apb slave port).
- Lets the CPU data port (m0) and the instruction-fetch/DMA port (m1) share the single SPI controller, including multi-cycle XIP flash reads.
- Serialises whole APB transfers with round-robin fairness, so one requester's transfer is never interleaved with the other's.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 4096, ACCESS-phase cycle limit before an error response (used only with the optional feature); must fit in 16 bits.

Ports:
- clock  input  1  single clock domain.
- reset  input  1  synchronous, active-high reset.
- m0_psel / m1_psel  input  1  requester select.
- m0_penable / m1_penable  input  1  requester enable.
- m0_pwrite / m1_pwrite  input  1  requester write.
- m0_paddr / m1_paddr  input  ADDR_W  requester address.
- m0_pwdata / m1_pwdata  input  DATA_W  requester write data.
- m0_pstrb / m1_pstrb  input  DATA_W/8  requester byte strobes.
- m0_pprot / m1_pprot  input  3  requester protection.
- m0_pready / m1_pready  output  1  completion to requester.
- m0_prdata / m1_prdata  output  DATA_W  read data to requester.
- m0_pslverr / m1_pslverr  output  1  error to requester.
- out_psel, out_penable, out_pwrite  output  1  to SPI completer.
- out_paddr  output  ADDR_W  to SPI completer.
- out_pwdata  output  DATA_W  to SPI completer.
- out_pstrb  output  DATA_W/8  to SPI completer.
- out_pprot  output  3  to SPI completer.
- out_pready, out_pslverr  input  1  from SPI completer.
- out_prdata  input  DATA_W  from SPI completer.
- grant  output  1  current/last owner, 0 = m0, 1 = m1.

Behaviour:
- Reset state: state = IDLE, rr pointer = 0, grant = 0.
- Reset values of all out_* signals and all m*_pready/pslverr/prdata: 0.
- Reset is honoured in any state: a transfer in flight is abandoned with no response, and the downstream bus is dropped immediately.
- State IDLE:
  - Requests are m*_psel levels.
  - Only m0 requesting -> grant m0. Only m1 requesting -> grant m1.
  - Both requesting -> grant the port that is not rr pointer's last winner.
  - On grant, register paddr, pwrite, pwdata, pstrb and pprot from the winner, set grant, and go to SETUP.
  - No request -> remain in IDLE.
- State SETUP (1 cycle): out_psel = 1, out_penable = 0, registered attributes driven. Next state ACCESS.
- State ACCESS:
  - out_psel = 1, out_penable = 1.
  - Wait any number of cycles for out_pready.
  - Cycle with out_pready = 1:
    - Granted m*_pready = 1, m*_prdata = out_prdata, m*_pslverr = out_pslverr, all combinational.
    - rr pointer updates to the winner.
    - Next state IDLE, with out_psel/out_penable = 0 in that IDLE cycle.
- Non-granted requester:
  - pready = 0 and prdata = 0 throughout; it simply waits, which is legal APB.
  - It is granted in the next IDLE cycle if it still holds psel.
- Latency: minimum 3 cycles from requester setup to pready (IDLE grant, SETUP, ACCESS with immediate out_pready).
- Back-to-back transfers: there is one IDLE cycle between them. With both requesting continuously, grants alternate strictly m0, m1, m0, ...
- Granted requester dropping psel mid-transfer is a protocol violation. It is ignored: the downstream transfer completes and the response is still driven on m*_pready.
- Attributes are taken only at grant time; changes on requester inputs after grant have no effect.
- m*_pslverr is only valid with m*_pready; it is 0 otherwise.

Optional Feature:
- Macro: SPI_APB_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter, cleared on SETUP, increments each ACCESS cycle without out_pready.
  - When the counter reaches TIMEOUT_CYCLES: granted requester gets pready = 1 and pslverr = 1 with prdata = 0 for one cycle, then state DRAIN.
  - DRAIN keeps out_psel = out_penable = 1 until out_pready, discards the response, then returns to IDLE. No grant is issued while in DRAIN.
  - rr pointer updates at the timeout.
- Not defined: no counter, no DRAIN state; ACCESS waits indefinitely.

Test Plan:
- m0 read of 0x30000004 alone, completer ready on 1st ACCESS cycle with prdata 0xDEADBEEF -> m0_pready high 3 cycles after setup, m0_prdata 0xDEADBEEF, m1_pready never high.
- m0 write 0x10001018 = 0x1 while m1 reads 0x30000000 in the same cycle, rr = 0 -> m1 granted first; m0's write appears on out_* only after m1's pready, with an IDLE cycle between.
- Both ports issue 4 back-to-back reads -> out_paddr order alternates m1, m0, m1, m0 ...; each requester receives its own data, and none is leaked to the other port.
- Completer holds pready low 200 cycles (XIP sequence) then returns pslverr = 1 -> granted requester sees pready + pslverr in that cycle; the other port stays stalled.
- Reset asserted during ACCESS -> next cycle all out_* = 0, no pready to either port; a new m0 request afterwards is granted normally.
- SPI_APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, completer never ready -> after 16 ACCESS cycles the requester gets pready + pslverr; the arbiter stays in DRAIN until a late out_pready, then grants a pending m1.

Source files
------------

// File: rtl/spi_apb_arbiter.sv
// Two-requester round-robin APB arbiter in front of the SPI/XIP completer.
// Optional ACCESS timeout with drain: define SPI_APB_ARB_TIMEOUT_EN.
module spi_apb_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                m0_psel,
   input  logic                m0_penable,
   input  logic                m0_pwrite,
   input  logic [ADDR_W-1:0]   m0_paddr,
   input  logic [DATA_W-1:0]   m0_pwdata,
   input  logic [DATA_W/8-1:0] m0_pstrb,
   input  logic [2:0]          m0_pprot,
   output logic                m0_pready,
   output logic [DATA_W-1:0]   m0_prdata,
   output logic                m0_pslverr,
   input  logic                m1_psel,
   input  logic                m1_penable,
   input  logic                m1_pwrite,
   input  logic [ADDR_W-1:0]   m1_paddr,
   input  logic [DATA_W-1:0]   m1_pwdata,
   input  logic [DATA_W/8-1:0] m1_pstrb,
   input  logic [2:0]          m1_pprot,
   output logic                m1_pready,
   output logic [DATA_W-1:0]   m1_prdata,
   output logic                m1_pslverr,
   output logic                out_psel,
   output logic                out_penable,
   output logic                out_pwrite,
   output logic [ADDR_W-1:0]   out_paddr,
   output logic [DATA_W-1:0]   out_pwdata,
   output logic [DATA_W/8-1:0] out_pstrb,
   output logic [2:0]          out_pprot,
   input  logic                out_pready,
   input  logic                out_pslverr,
   input  logic [DATA_W-1:0]   out_prdata,
   output logic                grant
);

   typedef struct packed {
      logic                write;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   wdata;
      logic [DATA_W/8-1:0] strb;
      logic [2:0]          prot;
   } attr_t;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
`ifdef SPI_APB_ARB_TIMEOUT_EN
      , DRAIN
`endif
   } state_t;

   state_t state_q, state_d;
   attr_t  m0_attr, m1_attr, attr_q;
   logic   rr_q;
   logic   grant_q;

   logic              take;
   logic              win;
   logic              rr_upd;
   logic              psel_c;
   logic              pen_c;
   logic              rsp;
   logic              rsp_err;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_v;

`ifdef SPI_APB_ARB_TIMEOUT_EN
   logic [15:0] cnt_q;
`endif

   // penable is implied by the requester's setup; the arbiter only needs psel
   logic unused_ok;
   assign unused_ok = &{1'b0, m0_penable, m1_penable,
                        16'(TIMEOUT_CYCLES)};

   assign m0_attr = '{write: m0_pwrite, addr: m0_paddr,
                      wdata: m0_pwdata, strb: m0_pstrb,
                      prot: m0_pprot};
   assign m1_attr = '{write: m1_pwrite, addr: m1_paddr,
                      wdata: m1_pwdata, strb: m1_pstrb,
                      prot: m1_pprot};

   always_comb begin
      state_d  = state_q;
      take     = 1'b0;
      win      = 1'b0;
      rr_upd   = 1'b0;
      psel_c   = 1'b0;
      pen_c    = 1'b0;
      rsp      = 1'b0;
      rsp_err  = 1'b0;
      rsp_data = '0;
      unique case (state_q)
         IDLE: begin
            if (m0_psel || m1_psel) begin
               take    = 1'b1;
               // on contention, favour whoever did not win last
               win     = (m0_psel && m1_psel) ? ~rr_q : m1_psel;
               state_d = SETUP;
            end
         end
         SETUP: begin
            psel_c  = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel_c = 1'b1;
            pen_c  = 1'b1;
            if (out_pready) begin
               rsp      = 1'b1;
               rsp_err  = out_pslverr;
               rsp_data = out_prdata;
               rr_upd   = 1'b1;
               state_d  = IDLE;
            end
`ifdef SPI_APB_ARB_TIMEOUT_EN
            else if (cnt_q == 16'(TIMEOUT_CYCLES)) begin
               rsp     = 1'b1;
               rsp_err = 1'b1;
               rr_upd  = 1'b1;
               state_d = DRAIN;
            end
`endif
         end
`ifdef SPI_APB_ARB_TIMEOUT_EN
         DRAIN: begin
            psel_c = 1'b1;
            pen_c  = 1'b1;
            if (out_pready) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         grant_q <= 1'b0;
         attr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            grant_q <= win;
            attr_q  <= win ? m1_attr : m0_attr;
         end
         if (rr_upd) rr_q <= grant_q;
      end
   end

`ifdef SPI_APB_ARB_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (state_q == SETUP) begin
         cnt_q <= '0;
      end else if (state_q == ACCESS && !out_pready) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end
`endif

   // an in-flight transfer is abandoned on reset: no response, bus dropped
   assign rsp_v = rsp & ~reset;

   assign m0_pready  = rsp_v & ~grant_q;
   assign m0_pslverr = rsp_v & ~grant_q & rsp_err;
   assign m0_prdata  = (rsp_v && !grant_q) ? rsp_data : '0;
   assign m1_pready  = rsp_v & grant_q;
   assign m1_pslverr = rsp_v & grant_q & rsp_err;
   assign m1_prdata  = (rsp_v && grant_q) ? rsp_data : '0;

   assign out_psel    = psel_c & ~reset;
   assign out_penable = pen_c & ~reset;
   assign out_pwrite  = attr_q.write;
   assign out_paddr   = attr_q.addr;
   assign out_pwdata  = attr_q.wdata;
   assign out_pstrb   = attr_q.strb;
   assign out_pprot   = attr_q.prot;
   assign grant       = grant_q;

endmodule
